// File: rtl/alu_mult_div_if.sv
// alu_mult_div_if -- bundle of the ALU, multiplier and divider signals.
//   master: drives operation select, operands, mul/div requests and sign selects.
//   slave : returns alu_result, mul_valid_out/mul_hi/mul_lo, div_valid_out/div_hi/div_lo.
interface alu_mult_div_if;
    logic [4:0]  alu_control;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [31:0] alu_result;
    logic        mul_valid_in;
    logic        mul_sign;
    logic        mul_valid_out;
    logic [31:0] mul_hi;
    logic [31:0] mul_lo;
    logic        div_valid_in;
    logic        div_sign;
    logic        div_valid_out;
    logic [31:0] div_hi;
    logic [31:0] div_lo;

    modport master (
        output alu_control, src_a, src_b, mul_valid_in, mul_sign, div_valid_in, div_sign,
        input  alu_result, mul_valid_out, mul_hi, mul_lo, div_valid_out, div_hi, div_lo
    );

    modport slave (
        input  alu_control, src_a, src_b, mul_valid_in, mul_sign, div_valid_in, div_sign,
        output alu_result, mul_valid_out, mul_hi, mul_lo, div_valid_out, div_hi, div_lo
    );
endinterface

// File: rtl/alu_mult_div.sv
// alu_mult_div -- combinational ALU plus independent 32-cycle sequential
// multiplier (shift-add) and divider (restoring).
// Ports:
//   clk   : single clock, rising edge
//   reset : synchronous, active-high; idles both units and zeroes their results
//   bus   : alu_mult_div_if.slave (operands, ALU select, mul/div handshakes, results)
// Configuration:
//   MULDIV_SIGNED_EN - when defined, mul_sign/div_sign select signed operation;
//                      otherwise every multiply/divide is unsigned.
module alu_mult_div (
    input logic          clk,
    input logic          reset,
    alu_mult_div_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    // ---------------- ALU ----------------
    logic [31:0] alu_res;
    always_comb begin
        alu_res = 32'h0;
        case (bus.alu_control)
            5'b00000: alu_res = bus.src_a & bus.src_b;
            5'b00001: alu_res = bus.src_a | bus.src_b;
            5'b00010: alu_res = bus.src_a + bus.src_b;
            5'b00011: alu_res = bus.src_a ^ bus.src_b;
            5'b00100: alu_res = bus.src_b << bus.src_a[4:0];
            5'b00101: alu_res = bus.src_b >> bus.src_a[4:0];
            5'b00110: alu_res = bus.src_a - bus.src_b;
            5'b00111: alu_res = {31'h0, $signed(bus.src_a) < $signed(bus.src_b)};
            5'b01000: alu_res = $unsigned($signed(bus.src_b) >>> bus.src_a[4:0]);
            5'b01001: alu_res = {31'h0, bus.src_a < bus.src_b};
            5'b01010: alu_res = ~(bus.src_a | bus.src_b);
            5'b01011: alu_res = {bus.src_b[15:0], 16'h0};
            default:  alu_res = 32'h0;
        endcase
    end
    assign bus.alu_result = alu_res;

    // ---------------- sign handling ----------------
    logic mul_signed, div_signed;
`ifdef MULDIV_SIGNED_EN
    assign mul_signed = bus.mul_sign;
    assign div_signed = bus.div_sign;
`else
    assign mul_signed = 1'b0;
    assign div_signed = 1'b0;
    logic unused_sign;
    assign unused_sign = bus.mul_sign ^ bus.div_sign;
`endif

    // Both units work on magnitudes and fix the sign at the end.
    logic        mul_a_neg, mul_b_neg, div_a_neg, div_b_neg;
    logic [31:0] mul_a_abs, mul_b_abs, div_a_abs, div_b_abs;
    assign mul_a_neg = mul_signed & bus.src_a[31];
    assign mul_b_neg = mul_signed & bus.src_b[31];
    assign div_a_neg = div_signed & bus.src_a[31];
    assign div_b_neg = div_signed & bus.src_b[31];
    assign mul_a_abs = mul_a_neg ? -bus.src_a : bus.src_a;
    assign mul_b_abs = mul_b_neg ? -bus.src_b : bus.src_b;
    assign div_a_abs = div_a_neg ? -bus.src_a : bus.src_a;
    assign div_b_abs = div_b_neg ? -bus.src_b : bus.src_b;

    // ---------------- multiplier ----------------
    // mul_acc = {partial product, remaining multiplier bits}; one bit per cycle.
    state_t      mul_state;
    logic [4:0]  mul_cnt;
    logic [31:0] mul_mcand;
    logic [63:0] mul_acc;
    logic        mul_neg;
    logic        mul_vld;
    logic [63:0] mul_res;
    logic [32:0] mul_sum;
    logic [63:0] mul_next, mul_prod;

    assign mul_sum  = {1'b0, mul_acc[63:32]} + (mul_acc[0] ? {1'b0, mul_mcand} : 33'h0);
    assign mul_next = {mul_sum, mul_acc[31:1]};
    assign mul_prod = mul_neg ? -mul_next : mul_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            mul_state <= IDLE;
            mul_cnt   <= 5'd0;
            mul_mcand <= 32'h0;
            mul_acc   <= 64'h0;
            mul_neg   <= 1'b0;
            mul_vld   <= 1'b0;
            mul_res   <= 64'h0;
        end else begin
            case (mul_state)
                IDLE: begin
                    mul_vld <= 1'b0;
                    if (bus.mul_valid_in) begin
                        mul_mcand <= mul_a_abs;
                        mul_acc   <= {32'h0, mul_b_abs};
                        mul_neg   <= mul_a_neg ^ mul_b_neg;
                        mul_cnt   <= 5'd0;
                        mul_state <= BUSY;
                    end
                end
                BUSY: begin
                    mul_acc <= mul_next;
                    mul_cnt <= mul_cnt + 5'd1;
                    // last step writes the signed-corrected product straight out
                    if (mul_cnt == 5'd31) begin
                        mul_res   <= mul_prod;
                        mul_vld   <= 1'b1;
                        mul_state <= DONE;
                    end
                end
                DONE: begin
                    mul_vld   <= 1'b0;
                    mul_state <= IDLE;
                end
                default: begin
                    mul_vld   <= 1'b0;
                    mul_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.mul_valid_out = mul_vld;
    assign bus.mul_hi        = mul_res[63:32];
    assign bus.mul_lo        = mul_res[31:0];

    // ---------------- divider ----------------
    // Quotient bits shift in at the bottom of div_quot while dividend bits
    // shift out of its top into the partial remainder.
    state_t      div_state;
    logic [4:0]  div_cnt;
    logic [31:0] div_dvsr, div_rem, div_quot;
    logic        div_qneg, div_rneg, div_zero;
    logic        div_vld;
    logic [63:0] div_res;
    logic [32:0] div_shift;
    logic        div_ge;
    logic [31:0] div_rem_nx, div_quot_nx, div_q_fin, div_r_fin;

    assign div_shift   = {div_rem, div_quot[31]};
    assign div_ge      = div_shift >= {1'b0, div_dvsr};
    // true difference is below the divisor, so 32-bit wrap is exact
    assign div_rem_nx  = div_ge ? (div_shift[31:0] - div_dvsr) : div_shift[31:0];
    assign div_quot_nx = {div_quot[30:0], div_ge};
    // divide by zero: all-ones quotient regardless of sign, remainder = dividend
    assign div_q_fin   = div_zero ? 32'hFFFF_FFFF : (div_qneg ? -div_quot_nx : div_quot_nx);
    assign div_r_fin   = div_rneg ? -div_rem_nx : div_rem_nx;

    always_ff @(posedge clk) begin
        if (reset) begin
            div_state <= IDLE;
            div_cnt   <= 5'd0;
            div_dvsr  <= 32'h0;
            div_rem   <= 32'h0;
            div_quot  <= 32'h0;
            div_qneg  <= 1'b0;
            div_rneg  <= 1'b0;
            div_zero  <= 1'b0;
            div_vld   <= 1'b0;
            div_res   <= 64'h0;
        end else begin
            case (div_state)
                IDLE: begin
                    div_vld <= 1'b0;
                    if (bus.div_valid_in) begin
                        div_dvsr  <= div_b_abs;
                        div_rem   <= 32'h0;
                        div_quot  <= div_a_abs;
                        div_qneg  <= div_a_neg ^ div_b_neg;
                        div_rneg  <= div_a_neg;
                        div_zero  <= (bus.src_b == 32'h0);
                        div_cnt   <= 5'd0;
                        div_state <= BUSY;
                    end
                end
                BUSY: begin
                    div_rem  <= div_rem_nx;
                    div_quot <= div_quot_nx;
                    div_cnt  <= div_cnt + 5'd1;
                    if (div_cnt == 5'd31) begin
                        div_res   <= {div_r_fin, div_q_fin};
                        div_vld   <= 1'b1;
                        div_state <= DONE;
                    end
                end
                DONE: begin
                    div_vld   <= 1'b0;
                    div_state <= IDLE;
                end
                default: begin
                    div_vld   <= 1'b0;
                    div_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.div_valid_out = div_vld;
    assign bus.div_hi        = div_res[63:32];
    assign bus.div_lo        = div_res[31:0];
endmodule

// File: tb/tb_alu_mult_div.sv
// tb_alu_mult_div -- directed self-checking bench for alu_mult_div.
// Expected values are hand-computed; signed cases switch on MULDIV_SIGNED_EN.
module tb_alu_mult_div;
    logic clk = 1'b0;
    logic reset;
    int   n_tot = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    alu_mult_div_if bus ();
    alu_mult_div dut (.clk(clk), .reset(reset), .bus(bus));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic alu(input string tag, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
        bus.alu_control = op;
        bus.src_a       = a;
        bus.src_b       = b;
        #1;
        chk(tag, {32'h0, bus.alu_result}, {32'h0, exp});
    endtask

    // Issue a mul (dv=0) or div (dv=1), hold valid until valid_out, scramble
    // operands right after capture, return {hi,lo} and cycles seen.
    task automatic run_op(input bit dv, input logic [31:0] a, input logic [31:0] b,
                          input logic sgn, output logic [63:0] res, output int lat);
        @(negedge clk);
        bus.src_a = a;
        bus.src_b = b;
        if (dv) begin bus.div_sign = sgn; bus.div_valid_in = 1'b1; end
        else    begin bus.mul_sign = sgn; bus.mul_valid_in = 1'b1; end
        lat = 0;
        while (!(dv ? bus.div_valid_out : bus.mul_valid_out) && lat < 100) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                bus.src_a = ~a;
                bus.src_b = ~b;
            end
        end
        res = dv ? {bus.div_hi, bus.div_lo} : {bus.mul_hi, bus.mul_lo};
        bus.mul_valid_in = 1'b0;
        bus.div_valid_in = 1'b0;
        @(negedge clk);
        chk(dv ? "div_pulse_end" : "mul_pulse_end",
            {63'h0, dv ? bus.div_valid_out : bus.mul_valid_out}, 64'h0);
    endtask

    initial begin
        logic [63:0] r;
        int          lat;
        int          seen;

        reset            = 1'b1;
        bus.alu_control  = 5'd0;
        bus.src_a        = 32'h0;
        bus.src_b        = 32'h0;
        bus.mul_valid_in = 1'b0;
        bus.mul_sign     = 1'b0;
        bus.div_valid_in = 1'b0;
        bus.div_sign     = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_mul_vld", {63'h0, bus.mul_valid_out}, 64'h0);
        chk("rst_div_vld", {63'h0, bus.div_valid_out}, 64'h0);
        chk("rst_mul", {bus.mul_hi, bus.mul_lo}, 64'h0);
        chk("rst_div", {bus.div_hi, bus.div_lo}, 64'h0);
        alu("alu_in_reset", 5'b00010, 32'd3, 32'd4, 32'd7);
        reset = 1'b0;

        // ALU sweep
        alu("and",  5'b00000, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200);
        alu("or",   5'b00001, 32'hF000_0001, 32'h0000_0F00, 32'hF000_0F01);
        alu("add",  5'b00010, 32'hFFFF_FFFF, 32'd2, 32'd1);
        alu("xor",  5'b00011, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF00F_F00F);
        alu("sll",  5'b00100, 32'd4, 32'h0000_0013, 32'h0000_0130);
        alu("srl",  5'b00101, 32'd4, 32'h8000_0000, 32'h0800_0000);
        alu("sub",  5'b00110, 32'd5, 32'd7, 32'hFFFF_FFFE);
        alu("slt",  5'b00111, 32'hFFFF_FFFF, 32'd1, 32'd1);
        alu("sltu", 5'b01001, 32'hFFFF_FFFF, 32'd1, 32'd0);
        alu("sra",  5'b01000, 32'd4, 32'h8000_0000, 32'hF800_0000);
        alu("nor",  5'b01010, 32'h0000_00FF, 32'hFF00_0000, 32'h00FF_FF00);
        alu("lui",  5'b01011, 32'h0, 32'hABCD_1234, 32'h1234_0000);
        alu("bad_code", 5'b11111, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0);
        alu("bad_code2", 5'b01100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);

        // multiply -3 x 7
        run_op(1'b0, 32'hFFFF_FFFD, 32'd7, 1'b1, r, lat);
        chk("mul_lat", 64'(lat), 64'd33);
`ifdef MULDIV_SIGNED_EN
        chk("mul_s_neg", r, 64'hFFFF_FFFF_FFFF_FFEB);
`else
        chk("mul_s_neg", r, 64'h0000_0006_FFFF_FFEB);
`endif
        chk("mul_hold", {bus.mul_hi, bus.mul_lo}, r);

        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, r, lat);
        chk("mul_u_max", r, 64'hFFFF_FFFE_0000_0001);
        chk("mul_u_lat", 64'(lat), 64'd33);

        run_op(1'b0, 32'hFFFF_FFFF, 32'd2, 1'b1, r, lat);
`ifdef MULDIV_SIGNED_EN
        chk("mul_m1x2", r, 64'hFFFF_FFFF_FFFF_FFFE);
`else
        chk("mul_m1x2", r, 64'h0000_0001_FFFF_FFFE);
`endif

        // divide
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1, r, lat);
        chk("div_lat", 64'(lat), 64'd33);
`ifdef MULDIV_SIGNED_EN
        chk("div_s_m7_2", r, 64'hFFFF_FFFF_FFFF_FFFD);
`else
        chk("div_s_m7_2", r, 64'h0000_0001_7FFF_FFFC);
`endif
        run_op(1'b1, 32'd100, 32'd0, 1'b0, r, lat);
        chk("div_by_zero", r, 64'h0000_0064_FFFF_FFFF);
        run_op(1'b1, 32'd1000, 32'd7, 1'b0, r, lat);
        chk("div_u", r, 64'h0000_0006_0000_008E);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, r, lat);
`ifdef MULDIV_SIGNED_EN
        chk("div_ovf", r, 64'h0000_0000_8000_0000);
`else
        chk("div_ovf", r, 64'h8000_0000_0000_0000);
`endif
        chk("mul_still_held", {32'h0, bus.mul_lo}, 64'h0000_0000_FFFF_FFFE);

        // reset mid-multiply
        @(negedge clk);
        bus.src_a = 32'd9; bus.src_b = 32'd9; bus.mul_sign = 1'b0;
        bus.mul_valid_in = 1'b1;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        bus.mul_valid_in = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.mul_valid_out) seen++;
        end
        chk("rst_no_pulse", 64'(seen), 64'd0);
        chk("rst_mul_zero", {bus.mul_hi, bus.mul_lo}, 64'h0);
        chk("rst_div_zero", {bus.div_hi, bus.div_lo}, 64'h0);
        run_op(1'b0, 32'd12345, 32'd1000, 1'b0, r, lat);
        chk("mul_after_rst", r, 64'd12345000);
        chk("mul_after_lat", 64'(lat), 64'd33);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_mult_div.md
ALU_MULT_DIV -- requirements
Module: alu_mult_div

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 alu_control  in  5  ALU operation select.
REQ-004 src_a  in  32  operand A; shift amount in src_a[4:0]; dividend / multiplicand.
REQ-005 src_b  in  32  operand B; value shifted; divisor / multiplier.
REQ-006 alu_result  out  32  combinational ALU result.
REQ-007 mul_valid_in  in  1  multiply request, held high until mul_valid_out seen.
REQ-008 mul_sign  in  1  1 = signed (MULT), 0 = unsigned (MULTU).
REQ-009 mul_valid_out  out  1  one-cycle product-ready pulse.
REQ-010 mul_hi, mul_lo  out  32 each  product upper/lower word.
REQ-011 div_valid_in  in  1  divide request, held high until div_valid_out seen.
REQ-012 div_sign  in  1  1 = signed (DIV), 0 = unsigned (DIVU).
REQ-013 div_valid_out  out  1  one-cycle quotient-ready pulse.
REQ-014 div_hi, div_lo  out  32 each  remainder (hi), quotient (lo).

Function
REQ-015 ALU SHALL be purely combinational; codes: 00000 AND, 00001 OR, 00010 ADD (wrap, no overflow trap), 00011 XOR, 00100 SLL src_b<<src_a[4:0], 00101 SRL logical, 00110 SUB (wrap), 00111 SLT signed (1/0), 01000 SRA arithmetic, 01001 SLTU unsigned, 01010 NOR, 01011 LUI {src_b[15:0],16'h0}.
REQ-016 Any other alu_control code SHALL yield alu_result = 0.
REQ-017 Multiplier and divider SHALL be independent sequential units, each with states IDLE, BUSY, DONE.
REQ-018 IDLE with valid_in=1 at an edge SHALL capture src_a, src_b, sign and enter BUSY; valid_in SHALL be ignored in BUSY and DONE.
REQ-019 Multiplier SHALL spend exactly 32 cycles in BUSY (shift-add, one bit per cycle), then DONE for exactly one cycle with mul_valid_out=1, then IDLE; capture edge E -> mul_valid_out high between edges E+32 and E+33.
REQ-020 Divider SHALL use identical timing (32-cycle restoring division) with div_valid_out.
REQ-021 mul_hi/mul_lo SHALL hold the full 64-bit product (two's complement when signed) from DONE until the next completion; likewise div_hi/div_lo.
REQ-022 Signed division SHALL truncate toward zero; remainder takes the dividend's sign.
REQ-023 Divide by zero SHALL give lo=32'hFFFFFFFF, hi=dividend, normal latency, no error flag.
REQ-024 Signed 32'h80000000 / 32'hFFFFFFFF SHALL give lo=32'h80000000, hi=0.
REQ-025 If valid_in still high in the cycle after DONE, a new operation SHALL start from IDLE (caller must drop valid_in on seeing valid_out).
REQ-026 Operand changes after capture SHALL not affect the running operation.

Reset
REQ-027 reset SHALL force both units to IDLE, clear mul_valid_out/div_valid_out, and zero mul_hi, mul_lo, div_hi, div_lo.
REQ-028 reset during BUSY or DONE SHALL abort the operation with no valid_out pulse; reset wins over a simultaneous valid_in.
REQ-029 alu_result SHALL be unaffected by reset.

Configuration
REQ-030 Macro MULDIV_SIGNED_EN: when defined, mul_sign/div_sign select signed operation per REQ-008/012; when undefined, sign inputs SHALL be ignored and all multiply/divide SHALL be unsigned (REQ-022/024 inapplicable).

Verification
REQ-031 ALU sweep: SUB 5-7 -> 32'hFFFFFFFE; SLT 0xFFFFFFFF vs 1 -> 1; SLTU same -> 0; SRA src_a=4, src_b=0x80000000 -> 0xF8000000; code 11111 -> 0.
REQ-032 Signed multiply -3 x 7, valid_in held -> mul_valid_out one pulse 32 cycles after capture, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-033 Unsigned multiply 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-034 Signed divide -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; unsigned 100 / 0 -> lo=0xFFFFFFFF, hi=100.
REQ-035 Reset asserted mid-multiply (cycle 10) -> no valid_out, hi=lo=0; next request completes normally.
REQ-036 Build without MULDIV_SIGNED_EN: mul_sign=1, -1 x 2 -> hi=1, lo=0xFFFFFFFE.
